// File: rtl/ifid_ctrl_pkg.sv
// Shared types and constants for the IF/ID pipeline sequencing controller.
// Control bundles are kept here so the FSM decode reads as a table of cases.
package ifid_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IMISS    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pc_redirect;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pc_redirect: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, pc_redirect: 1'b0};
  localparam ctrl_t CTRL_MISS     = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b0, pc_redirect: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, pc_redirect: 1'b1};
  localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, pc_redirect: 1'b0};

  // A flush always loads the NOP, so write enable must accompany it.
  function automatic ctrl_t fix_flush(input ctrl_t c);
    ctrl_t r;
    r = c;
    if (c.ifid_flush) r.ifid_write = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID sequencing controller: decides advance/hold/flush for PC and IF/ID each
// cycle from load-use, EX mispredict and imem readiness; keeps stall/flush counters.
module ifid_pipe_ctrl
  import ifid_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             ex_hit,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   mispredict;
  logic   load_use;
  logic   imiss;

  assign mispredict = ex_branch & (ex_taken != ex_hit);
  assign load_use   = idex_mem_read & (idex_rt != '0) &
                      ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));
  assign imiss      = ~imem_ready;

  always_comb begin
    ctrl    = CTRL_ADVANCE;
    state_d = RUN;
    case (state_q)
      IMISS: begin
        if (mispredict) begin
          ctrl    = CTRL_REDIRECT;
          state_d = REDIRECT;
        end else if (load_use) begin
          ctrl    = CTRL_LOAD_USE;
          state_d = IMISS;
        end else if (imiss) begin
          ctrl    = CTRL_MISS;
          state_d = IMISS;
        end
      end
      // IF/ID holds a bubble here, so a load-use match cannot be real.
      REDIRECT: begin
        if (mispredict) begin
          ctrl    = CTRL_REDIRECT;
          state_d = REDIRECT;
        end else if (imiss) begin
          ctrl    = CTRL_MISS;
          state_d = IMISS;
        end
      end
      RUN: begin
        if (mispredict) begin
          ctrl    = CTRL_REDIRECT;
          state_d = REDIRECT;
        end else if (load_use) begin
          ctrl    = CTRL_LOAD_USE;
        end else if (imiss) begin
          ctrl    = CTRL_MISS;
          state_d = IMISS;
        end
      end
      // Encoding 2'd3 decodes like RUN but always falls back to RUN.
      default: begin
        if (mispredict)     ctrl = CTRL_REDIRECT;
        else if (load_use)  ctrl = CTRL_LOAD_USE;
        else if (imiss)     ctrl = CTRL_MISS;
      end
    endcase
    if (rst) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
    end
    ctrl = fix_flush(ctrl);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign pc_redirect = ctrl.pc_redirect;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl.pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.pc_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Directed bench for ifid_pipe_ctrl; a second instance with 4-bit counters
// shares the stimulus and is used for the saturation check.
module tb_ifid_pipe_ctrl;
  import ifid_ctrl_pkg::*;

  localparam logic [4:0] C_ADV   = 5'b11000;
  localparam logic [4:0] C_LU    = 5'b00010;
  localparam logic [4:0] C_MISS  = 5'b01100;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_RST   = 5'b01110;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        id_uses_rt, idex_mem_read, ex_branch, ex_taken, ex_hit, imem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_write4, ifid_write4, ifid_flush4, idex_bubble4, pc_redirect4;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic [4:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect};

  ifid_pipe_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch(ex_branch),
    .ex_taken(ex_taken), .ex_hit(ex_hit), .imem_ready(imem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pc_redirect(pc_redirect),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ifid_pipe_ctrl #(.REG_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch(ex_branch),
    .ex_taken(ex_taken), .ex_hit(ex_hit), .imem_ready(imem_ready),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .pc_redirect(pc_redirect4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_rt = 5'd0;
    ex_branch = 1'b0; ex_taken = 1'b0; ex_hit = 1'b0;
    imem_ready = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_load_use();
    idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
  endtask

  task automatic set_mispredict();
    ex_branch = 1'b1; ex_taken = 1'b1; ex_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    n_checks++;
    if (ctl !== C_RST) begin
      $display("FAIL reset_outputs: got %b expected %b", ctl, C_RST); n_fail++;
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); n_fail++;
    end
    n_checks++;
    if (dut.state_q !== RUN) begin
      $display("FAIL reset_state: got %0d expected %0d", dut.state_q, RUN); n_fail++;
    end
    n_checks++;
    if (ctl !== C_ADV) begin
      $display("FAIL idle_advance: got %b expected %b", ctl, C_ADV); n_fail++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      $display("FAIL load_use_rs: got %b expected %b", ctl, C_LU); n_fail++;
    end
    tick();
    set_idle();
    n_checks++;
    if (stall_cnt !== 16'd1 || ctl !== C_ADV) begin
      $display("FAIL load_use_after: got cnt %0d ctl %b expected 1 %b", stall_cnt, ctl, C_ADV); n_fail++;
    end
    idex_mem_read = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      $display("FAIL load_use_r0: got %b expected %b", ctl, C_ADV); n_fail++;
    end
    tick();
    idex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      $display("FAIL load_use_rt: got %b expected %b", ctl, C_LU); n_fail++;
    end
    id_uses_rt = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      $display("FAIL load_use_rt_unused: got %b expected %b", ctl, C_ADV); n_fail++;
    end
    tick();
    n_checks++;
    if (stall_cnt !== 16'd1) begin
      $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); n_fail++;
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_mispredict();
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL mispredict_taken: got %b expected %b", ctl, C_REDIR); n_fail++;
    end
    tick();
    set_idle();
    set_load_use();
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      $display("FAIL redirect_ignores_lu: got %b expected %b", ctl, C_ADV); n_fail++;
    end
    n_checks++;
    if (flush_cnt !== 16'd1 || dut.state_q !== REDIRECT) begin
      $display("FAIL mispredict_cnt_state: got %0d/%0d expected 1/%0d", flush_cnt, dut.state_q, REDIRECT); n_fail++;
    end
    tick();
    set_idle();
    n_checks++;
    if (dut.state_q !== RUN || stall_cnt !== 16'd0) begin
      $display("FAIL redirect_to_run: got state %0d cnt %0d expected %0d 0", dut.state_q, stall_cnt, RUN); n_fail++;
    end
    ex_branch = 1'b1; ex_taken = 1'b0; ex_hit = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL mispredict_not_taken: got %b expected %b", ctl, C_REDIR); n_fail++;
    end
    ex_taken = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_ADV) begin
      $display("FAIL correct_predict: got %b expected %b", ctl, C_ADV); n_fail++;
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    set_mispredict();
    set_load_use();
    imem_ready = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL priority_mp: got %b expected %b", ctl, C_REDIR); n_fail++;
    end
    tick();
    set_idle();
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
      $display("FAIL priority_cnt: got %0d/%0d expected 0/1", stall_cnt, flush_cnt); n_fail++;
    end
    tick();
    set_load_use();
    imem_ready = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      $display("FAIL priority_lu_over_miss: got %b expected %b", ctl, C_LU); n_fail++;
    end
    tick();
    set_idle();
  endtask

  task automatic test_miss();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_MISS) begin
        $display("FAIL miss_cycle%0d: got %b expected %b", i, ctl, C_MISS); n_fail++;
      end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if (stall_cnt !== 16'd3 || ctl !== C_ADV) begin
      $display("FAIL miss_resume: got cnt %0d ctl %b expected 3 %b", stall_cnt, ctl, C_ADV); n_fail++;
    end
    tick();
    n_checks++;
    if (dut.state_q !== RUN || stall_cnt !== 16'd3) begin
      $display("FAIL miss_to_run: got %0d/%0d expected %0d/3", dut.state_q, stall_cnt, RUN); n_fail++;
    end
  endtask

  task automatic test_miss_mispredict();
    do_reset();
    imem_ready = 1'b0;
    tick();
    set_mispredict();
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL imiss_mp: got %b expected %b", ctl, C_REDIR); n_fail++;
    end
    tick();
    n_checks++;
    if (dut.state_q !== REDIRECT || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      $display("FAIL imiss_mp_state: got %0d %0d %0d expected %0d 1 1", dut.state_q, flush_cnt, stall_cnt, REDIRECT); n_fail++;
    end
    n_checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL redirect_again: got %b expected %b", ctl, C_REDIR); n_fail++;
    end
    tick();
    ex_branch = 1'b0;
    #1;
    n_checks++;
    if (dut.state_q !== REDIRECT || flush_cnt !== 16'd2 || ctl !== C_MISS) begin
      $display("FAIL redirect_miss: got %0d %0d %b expected %0d 2 %b", dut.state_q, flush_cnt, ctl, REDIRECT, C_MISS); n_fail++;
    end
    tick();
    set_load_use();
    #1;
    n_checks++;
    if (dut.state_q !== IMISS || ctl !== C_LU) begin
      $display("FAIL imiss_lu: got %0d %b expected %0d %b", dut.state_q, ctl, IMISS, C_LU); n_fail++;
    end
    tick();
    n_checks++;
    if (dut.state_q !== IMISS || stall_cnt !== 16'd3) begin
      $display("FAIL imiss_lu_stay: got %0d %0d expected %0d 3", dut.state_q, stall_cnt, IMISS); n_fail++;
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RST) begin
      $display("FAIL reset_mid_outputs: got %b expected %b", ctl, C_RST); n_fail++;
    end
    tick();
    rst = 1'b0;
    set_idle();
    n_checks++;
    if (dut.state_q !== RUN || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      $display("FAIL reset_mid: got %0d %0d %0d expected %0d 0 0", dut.state_q, stall_cnt, flush_cnt, RUN); n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    set_idle();
    n_checks++;
    if (stall_cnt4 !== 4'd15) begin
      $display("FAIL sat_cnt4: got %0d expected 15", stall_cnt4); n_fail++;
    end
    n_checks++;
    if (stall_cnt !== 16'd20) begin
      $display("FAIL sat_cnt16: got %0d expected 20", stall_cnt); n_fail++;
    end
    imem_ready = 1'b0;
    tick();
    set_idle();
    n_checks++;
    if (stall_cnt4 !== 4'd15) begin
      $display("FAIL sat_hold: got %0d expected 15", stall_cnt4); n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    tick();
    test_reset();
    test_load_use();
    test_mispredict();
    test_priority();
    test_miss();
    test_miss_mispredict();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_ctrl.md
# ifid_pipe_ctrl

Pipeline sequencing controller for the IF/ID stage of the 5-stage MIPS core. It decides each cycle whether the PC and IF/ID register advance, hold or are flushed. Inputs are the load-use hazard, a branch misprediction resolved in EX (branch taken versus the `hit` bit carried down the pipe), and instruction-memory readiness. It sits beside the IF/ID and ID/EX registers and drives their write-enable and flush controls. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `REG_W`, default 5: register-specifier width.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`, in, 1: clock. State and counters update on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `id_rs`, in, `REG_W`: rs field of the instruction in ID.
- `id_rt`, in, `REG_W`: rt field of the instruction in ID.
- `id_uses_rt`, in, 1: the ID instruction reads rt as a source.
- `idex_mem_read`, in, 1: the instruction in EX is a load.
- `idex_rt`, in, `REG_W`: destination of that load.
- `ex_branch`, in, 1: the EX instruction is a conditional branch.
- `ex_taken`, in, 1: branch outcome resolved in EX.
- `ex_hit`, in, 1: prediction bit carried from IF with the instruction (1 = predicted taken).
- `imem_ready`, in, 1: instruction memory returns valid data this cycle.
- `pc_write`, out, 1: PC register load enable.
- `ifid_write`, out, 1: IF/ID load enable.
- `ifid_flush`, out, 1: IF/ID loads a NOP (instruction 0, hit 0).
- `idex_bubble`, out, 1: ID/EX loads zeroed controls.
- `pc_redirect`, out, 1: select the EX-computed correct PC.
- `stall_cnt`, out, `CNT_W`: cycles with `pc_write` = 0.
- `flush_cnt`, out, `CNT_W`: misprediction redirects.

## Operation
Derived terms (combinational):
- mispredict = `ex_branch` & (`ex_taken` != `ex_hit`).
- load_use = `idex_mem_read` & `idex_rt` != 0 & (`idex_rt` == `id_rs` | (`id_uses_rt` & `idex_rt` == `id_rt`)).

FSM states: RUN, IMISS, REDIRECT. In every state, priority is mispredict > load_use > imem miss.

RUN:
- mispredict: `pc_redirect`=1, `pc_write`=1, `ifid_flush`=1, `idex_bubble`=1. Next state REDIRECT.
- load_use: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Next state RUN; the hazard clears once the load reaches MEM.
- !`imem_ready`: `pc_write`=0, `ifid_flush`=1. Next state IMISS.
- Otherwise: `pc_write`=1, `ifid_write`=1, all other controls 0.

IMISS:
- mispredict: same as RUN; the pending fetch is abandoned. Next state REDIRECT.
- load_use: as in RUN, and additionally `ifid_flush`=0. Stay in IMISS.
- !`imem_ready`: `pc_write`=0, `ifid_flush`=1.
- `imem_ready`: normal advance. Next state RUN.

REDIRECT:
- Lasts one cycle. IF/ID holds a bubble, so load_use is ignored.
- The mispredict check is still honoured. A second mispredict re-redirects and stays in REDIRECT.
- Otherwise: `imem_ready` gives a normal advance and next state RUN; !`imem_ready` behaves as the miss case and next state is IMISS.

Controls not listed for a case are 0. Whenever `ifid_flush`=1, `ifid_write` is also 1.

Counters:
- `stall_cnt` increments on each rising edge where `pc_write` was 0 and `rst`=0.
- `flush_cnt` increments on each rising edge where `pc_redirect` was 1.
- Both saturate at all-ones and never wrap.

## Timing
- Outputs are combinational from the current state and inputs, zero-cycle latency. They settle within the cycle, before the falling edge on which the pipeline registers capture.
- A redirect takes effect at the next pipeline edge. Exactly one IF/ID NOP and one ID/EX bubble are inserted per mispredict.
- Each load-use stall lasts exactly 1 cycle.
- While `rst`=1:
  - outputs forced to `pc_write`=0, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=1, `pc_redirect`=0;
  - at the edge, state goes to RUN and both counters clear to 0.
- Reset mid-IMISS or mid-REDIRECT returns the FSM to RUN on the next edge.

## Structure
- Package `ifid_ctrl_pkg` holds:
  - the state enum (RUN=2'd0, IMISS=2'd1, REDIRECT=2'd2);
  - the NOP encoding (32'h0).
- State 2'd3 is illegal. It decodes as RUN outputs and recovers to RUN on the next edge.
- Sub-module `sat_counter` (`CNT_W`, `clk`, `rst`, `inc`, `count`) is instantiated twice.

## Test plan
- Load-use: `idex_mem_read`=1, `idex_rt`=8, `id_rs`=8 → one cycle of `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; `stall_cnt`=1. Same stimulus with `idex_rt`=0 → no stall.
- Mispredict: `ex_branch`=1, `ex_taken`=1, `ex_hit`=0 → `pc_redirect`, `ifid_flush` and `idex_bubble` for 1 cycle; `flush_cnt`=1. The following cycle with load_use forced true → no stall.
- Priority: mispredict and load_use in the same cycle → redirect only; `stall_cnt` unchanged.
- Miss: hold `imem_ready`=0 for 3 cycles → `pc_write`=0 and `ifid_flush`=1 each cycle; `stall_cnt`=3; advance on the cycle `imem_ready`=1.
- Mispredict during IMISS → redirect; next state REDIRECT.
- Reset and saturation:
  - assert `rst` mid-IMISS → state RUN and counters 0 after one edge;
  - with `CNT_W`=4, 20 miss cycles → `stall_cnt` holds 15.
